// File: rtl/audio_volume_ramp_pkg.sv
// Shared definitions for the volume-ramp datapath: gain FSM states and gain helpers.
package audio_volume_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } gain_state_t;

  function automatic int unsigned unity_gain(input int unsigned vol_bit);
    return 32'd1 << (vol_bit - 1);
  endfunction

endpackage

// File: rtl/audio_volume_ramp_if.sv
// Sample-stream bundle between mixer, volume stage and serialiser.
interface audio_volume_ramp_if #(
  parameter int unsigned BIT = 24,
  parameter int unsigned CH  = 2
);
  logic              in_valid;
  logic [CH*BIT-1:0] in_data;
  logic              out_valid;
  logic [CH*BIT-1:0] out_data;
  logic [CH-1:0]     clip;

  modport master (output in_valid, in_data, input out_valid, out_data, clip);
  modport slave  (input in_valid, in_data, output out_valid, out_data, clip);
endinterface

// File: rtl/audio_volume_ramp_mul_sat.sv
// One channel of the volume datapath: stage 1 exact multiply, stage 2 shift and saturate.
module audio_volume_ramp_mul_sat #(
  parameter int unsigned BIT     = 24,
  parameter int unsigned VOL_BIT = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en_mul,
  input  logic               en_sat,
  input  logic [BIT-1:0]     sample,
  input  logic [VOL_BIT-1:0] gain,
  output logic [BIT-1:0]     out,
  output logic               clip
);
  localparam int unsigned PW = BIT + VOL_BIT + 1;
  localparam logic signed [PW-1:0] YMax = {{(VOL_BIT+2){1'b0}}, {(BIT-1){1'b1}}};
  localparam logic signed [PW-1:0] YMin = {{(VOL_BIT+2){1'b1}}, {(BIT-1){1'b0}}};

  logic signed [PW-1:0] samp_ext, gain_ext, prod_q, y;
  logic [BIT-1:0]       sat_d, out_q;
  logic                 clip_d, clip_q;

  // Both operands widened to the full product width so the product is exact.
  assign samp_ext = {{(VOL_BIT+1){sample[BIT-1]}}, sample};
  assign gain_ext = {{(BIT+1){1'b0}}, gain};
  assign y        = prod_q >>> (VOL_BIT - 1);

  always_comb begin
    sat_d  = y[BIT-1:0];
    clip_d = 1'b0;
    if (y > YMax) begin
      sat_d  = YMax[BIT-1:0];
      clip_d = 1'b1;
    end else if (y < YMin) begin
      sat_d  = YMin[BIT-1:0];
      clip_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prod_q <= '0;
      out_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      if (en_mul) prod_q <= samp_ext * gain_ext;
      if (en_sat) begin
        out_q  <= sat_d;
        clip_q <= clip_d;
      end
    end
  end

  assign out  = out_q;
  assign clip = clip_q;

endmodule

// File: rtl/audio_volume_ramp.sv
// Multi-channel volume stage: shared gain slews toward Volume (or 0 when muted) per accepted sample.
module audio_volume_ramp
  import audio_volume_ramp_pkg::*;
#(
  parameter int unsigned BIT     = 24,
  parameter int unsigned VOL_BIT = 8,
  parameter int unsigned CH      = 2,
  parameter int unsigned STEP    = 1
) (
  input  logic                CLK,
  input  logic                RST,
  audio_volume_ramp_if.slave  bus,
  input  logic [VOL_BIT-1:0]  Volume,
  input  logic                Mute,
  output logic                ramp_busy
);
  localparam logic [VOL_BIT:0] StepW = (VOL_BIT+1)'(STEP);

  logic [VOL_BIT-1:0] target, cur_gain_q, cur_gain_d;
  logic [VOL_BIT:0]   sum, diff;
  gain_state_t        state_q, state_d, dir;
  logic               v1_q, v2_q;

  always_comb begin
    target = Mute ? '0 : Volume;
    dir    = IDLE;
    if (cur_gain_q < target)      dir = RAMP_UP;
    else if (cur_gain_q > target) dir = RAMP_DOWN;
    sum        = {1'b0, cur_gain_q} + StepW;
    diff       = {1'b0, cur_gain_q} - {1'b0, target};
    cur_gain_d = cur_gain_q;
    // Clamp at target so a large STEP never overshoots or wraps.
    if (bus.in_valid) begin
      unique case (dir)
        RAMP_UP:   cur_gain_d = (sum > {1'b0, target}) ? target : sum[VOL_BIT-1:0];
        RAMP_DOWN: cur_gain_d = (diff < StepW) ? target : cur_gain_q - StepW[VOL_BIT-1:0];
        default:   cur_gain_d = cur_gain_q;
      endcase
    end
    state_d = IDLE;
    if (cur_gain_d < target)      state_d = RAMP_UP;
    else if (cur_gain_d > target) state_d = RAMP_DOWN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_gain_q <= '0;
      state_q    <= IDLE;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
    end else begin
      cur_gain_q <= cur_gain_d;
      state_q    <= state_d;
      v1_q       <= bus.in_valid;
      v2_q       <= v1_q;
    end
  end

  assign ramp_busy     = (state_q != IDLE);
  assign bus.out_valid = v2_q;

  // Each frame is scaled by the gain in force when it was accepted.
  for (genvar n = 0; n < CH; n++) begin : g_ch
    audio_volume_ramp_mul_sat #(
      .BIT     (BIT),
      .VOL_BIT (VOL_BIT)
    ) u_mul_sat (
      .CLK    (CLK),
      .RST    (RST),
      .en_mul (bus.in_valid),
      .en_sat (v1_q),
      .sample (bus.in_data[n*BIT +: BIT]),
      .gain   (cur_gain_q),
      .out    (bus.out_data[n*BIT +: BIT]),
      .clip   (bus.clip[n])
    );
  end

endmodule

// File: tb/tb_audio_volume_ramp.sv
// Scoreboard bench for audio_volume_ramp: STEP=1 instance (dut0) and STEP=4 instance (dut1).
module tb_audio_volume_ramp;
  import audio_volume_ramp_pkg::*;

  localparam int unsigned BIT     = 24;
  localparam int unsigned VOL_BIT = 8;
  localparam int unsigned CH      = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  audio_volume_ramp_if #(.BIT(BIT), .CH(CH)) bus0 ();
  audio_volume_ramp_if #(.BIT(BIT), .CH(CH)) bus1 ();

  logic [VOL_BIT-1:0] vol [2];
  logic               mute [2];
  logic               busy [2];

  audio_volume_ramp #(.BIT(BIT), .VOL_BIT(VOL_BIT), .CH(CH), .STEP(1)) dut0 (
    .CLK(CLK), .RST(RST), .bus(bus0), .Volume(vol[0]), .Mute(mute[0]), .ramp_busy(busy[0])
  );
  audio_volume_ramp #(.BIT(BIT), .VOL_BIT(VOL_BIT), .CH(CH), .STEP(4)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1), .Volume(vol[1]), .Mute(mute[1]), .ramp_busy(busy[1])
  );

  typedef struct {
    int              d;
    int              due;
    logic [2*BIT-1:0] data;
    logic [1:0]      clip;
  } exp_t;

  exp_t             sb[$];
  int               n_vec = 0;
  int               n_err = 0;
  int               cyc   = 0;
  int               gm [2];
  int               steps [2];
  logic [2*BIT-1:0] last [2];
  logic             hold_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int tgt(input int d);
    return mute[d] ? 0 : int'(vol[d]);
  endfunction

  function automatic int nxt(input int cur, input int t, input int s);
    if (cur < t) return (cur + s > t) ? t : cur + s;
    if (cur > t) return (cur - s < t) ? t : cur - s;
    return cur;
  endfunction

  // Returns {clip, sample} for one channel.
  function automatic logic [BIT:0] scale(input logic [BIT-1:0] x, input int g);
    longint p, q, mx, mn;
    mx = (longint'(1) <<< (BIT - 1)) - 1;
    mn = -(longint'(1) <<< (BIT - 1));
    p  = longint'($signed(x)) * longint'(g);
    q  = p >>> (VOL_BIT - 1);
    if (q > mx) return {1'b1, mx[BIT-1:0]};
    if (q < mn) return {1'b1, mn[BIT-1:0]};
    return {1'b0, q[BIT-1:0]};
  endfunction

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_in(input int d, input logic v, input logic [2*BIT-1:0] data);
    if (d == 0) begin
      bus0.in_valid = v;
      bus0.in_data  = data;
    end else begin
      bus1.in_valid = v;
      bus1.in_data  = data;
    end
  endtask

  task automatic send(input int d, input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                      input logic hand, input logic [2*BIT-1:0] hd, input logic [1:0] hc);
    logic [BIT:0] r0, r1;
    exp_t e;
    r0     = scale(a, gm[d]);
    r1     = scale(b, gm[d]);
    e.d    = d;
    e.due  = cyc + 2;
    e.data = hand ? hd : {r1[BIT-1:0], r0[BIT-1:0]};
    e.clip = hand ? hc : {r1[BIT], r0[BIT]};
    sb.push_back(e);
    gm[d] = nxt(gm[d], tgt(d), steps[d]);
    set_in(d, 1'b1, {b, a});
    cycle();
    set_in(d, 1'b0, {b, a});
    chk("ramp_busy", 64'(busy[d]), 64'(gm[d] != tgt(d)));
  endtask

  task automatic apply(input int d, input logic [BIT-1:0] a, input logic [BIT-1:0] b);
    send(d, a, b, 1'b0, '0, 2'b00);
  endtask

  task automatic apply_hand(input int d, input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                            input logic [BIT-1:0] ea, input logic [BIT-1:0] eb,
                            input logic [1:0] ec);
    send(d, a, b, 1'b1, {eb, ea}, ec);
  endtask

  task automatic mon(input int d);
    logic             ov;
    logic [2*BIT-1:0] od;
    logic [1:0]       oc;
    int               idx;
    exp_t             e;
    ov  = (d == 0) ? bus0.out_valid : bus1.out_valid;
    od  = (d == 0) ? bus0.out_data : bus1.out_data;
    oc  = (d == 0) ? bus0.clip : bus1.clip;
    idx = -1;
    if (ov) begin
      foreach (sb[i]) if (idx < 0 && sb[i].d == d) idx = i;
      if (idx < 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        e = sb[idx];
        sb.delete(idx);
        chk("out_data", 64'(od), 64'(e.data));
        chk("clip", 64'(oc), 64'(e.clip));
        chk("latency", 64'(cyc), 64'(e.due));
        last[d] = od;
      end
    end else if (hold_en) begin
      chk("hold", 64'(od), 64'(last[d]));
    end
  endtask

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    steps[0] = 1;
    steps[1] = 4;
    gm[0]    = 0;
    gm[1]    = 0;
    last[0]  = '0;
    last[1]  = '0;
    vol[0]   = '0;
    vol[1]   = '0;
    mute[0]  = 1'b0;
    mute[1]  = 1'b0;
    RST      = 1'b1;
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);
    idle(3);
    RST = 1'b0;
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus0.out_data), 64'd0);
    chk("rst_clip", 64'(bus0.clip), 64'd0);
    chk("rst_ramp_busy", 64'(busy[0]), 64'd0);
    hold_en = 1'b1;

    // Fade-in from silence to unity; ch0 = +0.5 FS, ch1 = -0.5 FS reveal the gain.
    vol[0] = VOL_BIT'(unity_gain(VOL_BIT));
    repeat (128) apply(0, 24'h400000, 24'hC00000);
    apply_hand(0, 24'h100000, 24'hFFFFFF, 24'h100000, 24'hFFFFFF, 2'b00);

    // Max gain: saturation both ways, then small exact value, then floor at gain 64.
    vol[0] = 8'd255;
    repeat (127) apply(0, 24'h400000, 24'hC00000);
    apply_hand(0, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 2'b11);
    apply_hand(0, 24'h000100, 24'h000100, 24'h0001FE, 24'h0001FE, 2'b00);
    vol[0] = 8'd64;
    repeat (191) apply(0, 24'h400000, 24'hC00000);
    apply_hand(0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 2'b00);

    // Soft mute down to zero, unmute, redirect mid-ramp.
    vol[0] = 8'd128;
    repeat (64) apply(0, 24'h400000, 24'hC00000);
    mute[0] = 1'b1;
    repeat (128) apply(0, 24'h400000, 24'hC00000);
    apply_hand(0, 24'h400000, 24'hC00000, 24'h000000, 24'h000000, 2'b00);
    mute[0] = 1'b0;
    repeat (60) apply(0, 24'h400000, 24'hC00000);
    vol[0] = 8'd100;
    repeat (50) apply(0, 24'h400000, 24'hC00000);
    vol[0] = 8'd128;
    repeat (10) apply(0, 24'h400000, 24'hC00000);
    vol[0] = 8'd100;
    repeat (15) apply(0, 24'h400000, 24'hC00000);
    apply_hand(0, 24'h400000, 24'hC00000, 24'h320000, 24'hCE0000, 2'b00);

    // Sparse valids while ramping, then back-to-back.
    vol[0] = 8'd120;
    repeat (6) begin
      apply(0, 24'h400000, 24'hC00000);
      idle(4);
    end
    repeat (4) apply(0, 24'h400000, 24'hC00000);

    // STEP=4 clamping on dut1: 126->128 (not 130), 2->0 (no wrap).
    vol[1] = 8'd128;
    repeat (32) apply(1, 24'h400000, 24'hC00000);
    vol[1] = 8'd126;
    apply(1, 24'h400000, 24'hC00000);
    vol[1] = 8'd128;
    apply(1, 24'h400000, 24'hC00000);
    apply_hand(1, 24'h400000, 24'hC00000, 24'h400000, 24'hC00000, 2'b00);
    vol[1] = 8'd2;
    repeat (32) apply(1, 24'h400000, 24'hC00000);
    vol[1] = 8'd0;
    apply(1, 24'h400000, 24'hC00000);
    apply_hand(1, 24'h400000, 24'hC00000, 24'h000000, 24'h000000, 2'b00);

    // Reset mid-ramp with two frames in flight; neither may emerge.
    idle(3);
    vol[0] = 8'd200;
    apply(0, 24'h400000, 24'hC00000);
    idle(3);
    set_in(0, 1'b1, {24'h123456, 24'h400000});
    cycle();
    RST = 1'b1;
    set_in(0, 1'b1, {24'h654321, 24'h400000});
    cycle();
    RST = 1'b0;
    set_in(0, 1'b0, '0);
    gm[0]   = 0;
    gm[1]   = 0;
    last[0] = '0;
    last[1] = '0;
    chk("post_rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("post_rst_out_data", 64'(bus0.out_data), 64'd0);
    chk("post_rst_ramp_busy", 64'(busy[0]), 64'd0);
    idle(3);
    repeat (5) apply(0, 24'h400000, 24'hC00000);
    apply_hand(0, 24'h400000, 24'hC00000, 24'h028000, 24'hFD8000, 2'b00);

    idle(4);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
